// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_pkg
//  Purpose  : Shared types and rule tables for the Life generation engine.
//             Rule masks are indexed by live-neighbour count (0..8).
//  Revision : 1.0  initial release
// ============================================================================
package life_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
   localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

   // Next state of one cell from its current state and neighbour count
   function automatic logic cell_next(input logic alive, input logic [3:0] cnt);
      logic res;
      res = 1'b0;
      if (cnt <= 4'd8) begin
         res = alive ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
      end
      return res;
   endfunction

endpackage : life_pkg
`default_nettype wire

// File: rtl/life_row_next.sv
`default_nettype none
// ============================================================================
//  Module   : life_row_next
//  Purpose  : Combinational next-generation row from the row above, the
//             current row and the row below. Column edges wrap when
//             LIFE_WRAP_EN is defined, otherwise pad with dead cells.
//  Revision : 1.0  initial release
// ============================================================================
module life_row_next
   import life_pkg::*;
#(
   parameter int GRID_W = 16
) (
   input  logic [GRID_W-1:0] above,
   input  logic [GRID_W-1:0] cur,
   input  logic [GRID_W-1:0] below,
   output logic [GRID_W-1:0] nxt
);

   // Extended rows: bit 0 is column -1, bit GRID_W+1 is column GRID_W
   logic [GRID_W+1:0] w_a_ext;
   logic [GRID_W+1:0] w_c_ext;
   logic [GRID_W+1:0] w_b_ext;

`ifdef LIFE_WRAP_EN
   assign w_a_ext = {above[0], above, above[GRID_W-1]};
   assign w_c_ext = {cur[0],   cur,   cur[GRID_W-1]};
   assign w_b_ext = {below[0], below, below[GRID_W-1]};
`else
   assign w_a_ext = {1'b0, above, 1'b0};
   assign w_c_ext = {1'b0, cur,   1'b0};
   assign w_b_ext = {1'b0, below, 1'b0};
`endif

   for (genvar x = 0; x < GRID_W; x++) begin : g_col
      logic [3:0] w_cnt;
      assign w_cnt = 4'(w_a_ext[x]) + 4'(w_a_ext[x+1]) + 4'(w_a_ext[x+2])
                   + 4'(w_c_ext[x])                    + 4'(w_c_ext[x+2])
                   + 4'(w_b_ext[x]) + 4'(w_b_ext[x+1]) + 4'(w_b_ext[x+2]);
      assign nxt[x] = cell_next(cur[x], w_cnt);
   end

endmodule : life_row_next
`default_nettype wire

// File: rtl/life_gen_engine.sv
`default_nettype none
// ============================================================================
//  Module   : life_gen_engine
//  Purpose  : Holds the Life cell array and evolves it one generation per
//             rising edge of envolve_v, updating one row per clock in place.
//             Optional macro: LIFE_WRAP_EN (toroidal grid).
//  Revision : 1.0  initial release
// ============================================================================
module life_gen_engine
   import life_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic                      envolve_v,
   input  logic                      clear,
   input  logic                      edit_we,
   input  logic [$clog2(GRID_W)-1:0] edit_x,
   input  logic [$clog2(GRID_H)-1:0] edit_y,
   input  logic                      edit_val,
   input  logic [$clog2(GRID_H)-1:0] rd_y,
   output logic [GRID_W-1:0]         rd_row,
   output logic                      busy,
   output logic                      gen_done,
   output logic [GEN_W-1:0]          gen_count
);

   localparam int YW = $clog2(GRID_H);
   localparam logic [YW-1:0] LAST_ROW = YW'(GRID_H - 1);

   logic [GRID_W-1:0] r_grid [GRID_H];
   state_e            r_state;
   logic              r_ev_q;
   logic [YW-1:0]     r_row;
   logic [GRID_W-1:0] r_prev_old;
`ifdef LIFE_WRAP_EN
   logic [GRID_W-1:0] r_first_old;
`endif
   logic [GEN_W-1:0]  r_gen_count;

   logic              w_req;
   logic [GRID_W-1:0] w_below;
   logic [GRID_W-1:0] w_next_row;

   assign w_req     = envolve_v & ~r_ev_q & mode & (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign gen_done  = (r_state == DONE);
   assign gen_count = r_gen_count;

   // Row below the one being updated: old row 0 wraps in for the last row
   always_comb begin
      w_below = '0;
      if (r_row == LAST_ROW) begin
`ifdef LIFE_WRAP_EN
         w_below = r_first_old;
`endif
      end else begin
         w_below = r_grid[r_row + 1'b1];
      end
   end

   life_row_next #(
      .GRID_W (GRID_W)
   ) u_row_next (
      .above (r_prev_old),
      .cur   (r_grid[r_row]),
      .below (w_below),
      .nxt   (w_next_row)
   );

   // Display read port; out-of-range rows read as empty
   always_comb begin
      rd_row = '0;
      if (32'(rd_y) < GRID_H) begin
         rd_row = r_grid[rd_y];
      end
   end

   // Sequencer, array update, edit/clear handling and generation counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < GRID_H; i++) begin
            r_grid[i] <= '0;
         end
         r_state     <= IDLE;
         r_ev_q      <= 1'b0;
         r_row       <= '0;
         r_prev_old  <= '0;
`ifdef LIFE_WRAP_EN
         r_first_old <= '0;
`endif
         r_gen_count <= '0;
      end else begin
         r_ev_q <= envolve_v;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_state     <= SCAN;
                  r_row       <= '0;
`ifdef LIFE_WRAP_EN
                  r_prev_old  <= r_grid[LAST_ROW];
                  r_first_old <= r_grid[0];
`else
                  r_prev_old  <= '0;
`endif
               end else if (clear) begin
                  for (int i = 0; i < GRID_H; i++) begin
                     r_grid[i] <= '0;
                  end
                  r_gen_count <= '0;
               end else if (edit_we && (32'(edit_x) < GRID_W) && (32'(edit_y) < GRID_H)) begin
                  r_grid[edit_y][edit_x] <= edit_val;
               end
            end
            SCAN: begin
               r_grid[r_row] <= w_next_row;
               r_prev_old    <= r_grid[r_row];
               if (r_row == LAST_ROW) begin
                  r_row       <= '0;
                  r_state     <= DONE;
                  r_gen_count <= r_gen_count + 1'b1;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : life_gen_engine
`default_nettype wire
